// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the two writeback requester handshakes and the register file write
// port that the arbiter drives.
//
// Signals:
//   req0_valid/req0_addr/req0_data  requester 0 write request (master drives)
//   req0_ready                      requester 0 accept (arbiter drives)
//   req1_valid/req1_addr/req1_data  requester 1 write request (master drives)
//   req1_ready                      requester 1 accept (arbiter drives)
//   RegWrite/WriteRegister/WriteData registered register file write port
//   grant_id                        requester whose write is on the port
//   idle                            no buffered or in-flight write
//
// Modports:
//   master  requesters plus register file side
//   slave   the arbiter
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
);

  logic              req0_valid;
  logic              req0_ready;
  logic [AWIDTH-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [AWIDTH-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_data;

  logic              RegWrite;
  logic [AWIDTH-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic              grant_id;
  logic              idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, WriteRegister, WriteData, grant_id, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, WriteRegister, WriteData, grant_id, idle
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register file's single write port between two writeback
// requesters. Each requester has a one-entry holding buffer behind a
// valid/ready handshake; pending writes are granted round-robin and driven to
// the register file from registered outputs. Writes to register 0 are
// acknowledged but dropped.
//
// Ports:
//   Clk    clock, all state updates on the rising edge
//   Reset  synchronous, active-high reset
//   bus    regfile_write_arbiter_if.slave (requester handshakes + write port)
//   grant_count0/grant_count1/zero_drop_count (optional, 16-bit saturating)
//
// Configuration:
//   REGFILE_ARB_STATS_EN  when defined, adds the statistics counter outputs.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  regfile_write_arbiter_if.slave  bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]             grant_count0,
  output logic [15:0]             grant_count1,
  output logic [15:0]             zero_drop_count
`endif
);

  logic              buf0Full_q, buf0Full_d;
  logic [AWIDTH-1:0] buf0Addr_q, buf0Addr_d;
  logic [WIDTH-1:0]  buf0Data_q, buf0Data_d;
  logic              buf1Full_q, buf1Full_d;
  logic [AWIDTH-1:0] buf1Addr_q, buf1Addr_d;
  logic [WIDTH-1:0]  buf1Data_q, buf1Data_d;
  logic              prio_q, prio_d;
  logic              regWrite_q, regWrite_d;
  logic [AWIDTH-1:0] writeReg_q, writeReg_d;
  logic [WIDTH-1:0]  writeData_q, writeData_d;
  logic              grantId_q, grantId_d;

  logic grant0, grant1;
  logic ready0, ready1;
  logic accept0, accept1;
  logic load0, load1;

  // Grants come purely from buffer state: a lone full buffer always wins,
  // and when both are full the round-robin pointer decides.
  always_comb begin
    grant0 = buf0Full_q && (!buf1Full_q || !prio_q);
    grant1 = buf1Full_q && (!buf0Full_q || prio_q);
  end

  // A buffer can take a new write when empty or when it is draining this
  // cycle, so a lone requester streams one write per cycle. Ready is held
  // low during reset so nothing is acknowledged and then discarded.
  always_comb begin
    ready0  = !Reset && (!buf0Full_q || grant0);
    ready1  = !Reset && (!buf1Full_q || grant1);
    accept0 = bus.req0_valid && ready0;
    accept1 = bus.req1_valid && ready1;
    load0   = accept0 && (bus.req0_addr != '0);
    load1   = accept1 && (bus.req1_addr != '0);
  end

  // Next-state for the buffers, the round-robin pointer and the write port.
  // A refill on the drain edge wins over the drain so no write is lost.
  always_comb begin
    buf0Full_d  = buf0Full_q;
    buf0Addr_d  = buf0Addr_q;
    buf0Data_d  = buf0Data_q;
    buf1Full_d  = buf1Full_q;
    buf1Addr_d  = buf1Addr_q;
    buf1Data_d  = buf1Data_q;
    prio_d      = prio_q;
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    grantId_d   = grantId_q;

    if (grant0) begin
      buf0Full_d = 1'b0;
    end
    if (grant1) begin
      buf1Full_d = 1'b0;
    end
    if (load0) begin
      buf0Full_d = 1'b1;
      buf0Addr_d = bus.req0_addr;
      buf0Data_d = bus.req0_data;
    end
    if (load1) begin
      buf1Full_d = 1'b1;
      buf1Addr_d = bus.req1_addr;
      buf1Data_d = bus.req1_data;
    end

    // The pointer always moves to the requester that did not just win.
    if (grant0) begin
      regWrite_d  = 1'b1;
      writeReg_d  = buf0Addr_q;
      writeData_d = buf0Data_q;
      grantId_d   = 1'b0;
      prio_d      = 1'b1;
    end else if (grant1) begin
      regWrite_d  = 1'b1;
      writeReg_d  = buf1Addr_q;
      writeData_d = buf1Data_q;
      grantId_d   = 1'b1;
      prio_d      = 1'b0;
    end
  end

  // State registers; reset discards any buffered write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      buf0Full_q  <= 1'b0;
      buf0Addr_q  <= '0;
      buf0Data_q  <= '0;
      buf1Full_q  <= 1'b0;
      buf1Addr_q  <= '0;
      buf1Data_q  <= '0;
      prio_q      <= 1'b0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
      grantId_q   <= 1'b0;
    end else begin
      buf0Full_q  <= buf0Full_d;
      buf0Addr_q  <= buf0Addr_d;
      buf0Data_q  <= buf0Data_d;
      buf1Full_q  <= buf1Full_d;
      buf1Addr_q  <= buf1Addr_d;
      buf1Data_q  <= buf1Data_d;
      prio_q      <= prio_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
      grantId_q   <= grantId_d;
    end
  end

  assign bus.req0_ready    = ready0;
  assign bus.req1_ready    = ready1;
  assign bus.RegWrite      = regWrite_q;
  assign bus.WriteRegister = writeReg_q;
  assign bus.WriteData     = writeData_q;
  assign bus.grant_id      = grantId_q;
  assign bus.idle          = !buf0Full_q && !buf1Full_q && !regWrite_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] grantCount0_q, grantCount0_d;
  logic [15:0] grantCount1_q, grantCount1_d;
  logic [15:0] zeroDrop_q, zeroDrop_d;
  logic [15:0] dropInc;

  // Saturating statistics; both requesters dropping in one cycle adds two.
  always_comb begin
    dropInc = {15'd0, accept0 && (bus.req0_addr == '0)}
            + {15'd0, accept1 && (bus.req1_addr == '0)};
    grantCount0_d = grantCount0_q;
    grantCount1_d = grantCount1_q;
    zeroDrop_d    = zeroDrop_q;
    if (grant0 && (grantCount0_q != 16'hFFFF)) begin
      grantCount0_d = grantCount0_q + 16'd1;
    end
    if (grant1 && (grantCount1_q != 16'hFFFF)) begin
      grantCount1_d = grantCount1_q + 16'd1;
    end
    if (zeroDrop_q > (16'hFFFF - dropInc)) begin
      zeroDrop_d = 16'hFFFF;
    end else begin
      zeroDrop_d = zeroDrop_q + dropInc;
    end
  end

  // Counter registers, cleared with the rest of the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grantCount0_q <= '0;
      grantCount1_q <= '0;
      zeroDrop_q    <= '0;
    end else begin
      grantCount0_q <= grantCount0_d;
      grantCount1_q <= grantCount1_d;
      zeroDrop_q    <= zeroDrop_d;
    end
  end

  assign grant_count0    = grantCount0_q;
  assign grant_count1    = grantCount1_q;
  assign zero_drop_count = zeroDrop_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Self-checking bench for regfile_write_arbiter. Each scenario task pushes the
// writes it expects onto a scoreboard queue; a monitor pops and compares every
// write that appears on the register file port. Any write with nothing
// expected is an error.
// Honors REGFILE_ARB_STATS_EN to connect and check the statistics counters.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int WIDTH  = 32;
  localparam int AWIDTH = 5;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              id;
  } wr_t;

  logic Clk = 1'b0;
  logic Reset;

  regfile_write_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) rfIf ();

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] grant_count0, grant_count1, zero_drop_count;
`endif

  regfile_write_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (rfIf.slave)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .grant_count0    (grant_count0),
    .grant_count1    (grant_count1),
    .zero_drop_count (zero_drop_count)
`endif
  );

  int  assertCount = 0;
  int  failCount   = 0;
  int  cycleCnt    = 0;
  int  grantsSeen0 = 0;
  int  grantsSeen1 = 0;
  wr_t expQ[$];
  int  writeCycles[$];
  wr_t monExp;

  // Free-running clock and cycle counter for gap checks.
  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  // Scoreboard monitor: every write on the port must match the next expected.
  always @(negedge Clk) begin
    if (rfIf.RegWrite === 1'b1) begin
      writeCycles.push_back(cycleCnt);
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h id=%0d, required no write",
                 rfIf.WriteRegister, rfIf.WriteData, rfIf.grant_id);
      end else begin
        monExp = expQ.pop_front();
        if (monExp.id) grantsSeen1++;
        else           grantsSeen0++;
        if ({rfIf.WriteRegister, rfIf.WriteData, rfIf.grant_id} !==
            {monExp.addr, monExp.data, monExp.id}) begin
          failCount++;
          $display("[TB] FAIL write_port: got addr=%0d data=%h id=%0d, required addr=%0d data=%h id=%0d",
                   rfIf.WriteRegister, rfIf.WriteData, rfIf.grant_id,
                   monExp.addr, monExp.data, monExp.id);
        end
      end
    end
  end

  // Waits (bounded) until the scoreboard has consumed all expected writes.
  task automatic wait_drain();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    Reset           = 1'b1;
    rfIf.req0_valid = 1'b1;
    rfIf.req0_addr  = 5'd3;
    rfIf.req0_data  = 32'hAAAA_5555;
    rfIf.req1_valid = 1'b0;
    rfIf.req1_addr  = '0;
    rfIf.req1_data  = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    assertCount++;
    if (rfIf.req0_ready !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_ready0: got %b, required 0", rfIf.req0_ready);
    end
    assertCount++;
    if (rfIf.RegWrite !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_regwrite: got %b, required 0", rfIf.RegWrite);
    end
    assertCount++;
    if (rfIf.WriteRegister !== 5'd0) begin
      failCount++; $display("[TB] FAIL reset_writereg: got %0d, required 0", rfIf.WriteRegister);
    end
    assertCount++;
    if (rfIf.WriteData !== 32'd0) begin
      failCount++; $display("[TB] FAIL reset_writedata: got %h, required 0", rfIf.WriteData);
    end
    assertCount++;
    if (rfIf.idle !== 1'b1 || rfIf.grant_id !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_idle_grant: got idle=%b grant=%b, required 1/0",
                            rfIf.idle, rfIf.grant_id);
    end
    rfIf.req0_valid = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (4) @(negedge Clk);
    assertCount++;
    if (rfIf.idle !== 1'b1 || rfIf.req0_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL post_reset_idle: got idle=%b ready0=%b, required 1/1",
                            rfIf.idle, rfIf.req0_ready);
    end
  endtask

  task automatic test_contention();
    logic [AWIDTH-1:0] list0 [3];
    logic [AWIDTH-1:0] list1 [3];
    int  i0 = 0, i1 = 0, n = 0;
    bit  a0, a1;
    $display("[TB] test_contention");
    list0 = '{5'd1, 5'd2, 5'd3};
    list1 = '{5'd9, 5'd10, 5'd11};
    writeCycles.delete();
    for (int k = 0; k < 3; k++) begin
      expQ.push_back('{addr: list0[k], data: 32'h0000_0100 + 32'(list0[k]), id: 1'b0});
      expQ.push_back('{addr: list1[k], data: 32'h0000_0200 + 32'(list1[k]), id: 1'b1});
    end
    @(posedge Clk);
    #1;
    rfIf.req0_valid = 1'b1; rfIf.req0_addr = list0[0]; rfIf.req0_data = 32'h0000_0100 + 32'(list0[0]);
    rfIf.req1_valid = 1'b1; rfIf.req1_addr = list1[0]; rfIf.req1_data = 32'h0000_0200 + 32'(list1[0]);
    while ((i0 < 3 || i1 < 3) && n < 30) begin
      @(negedge Clk);
      a0 = rfIf.req0_valid && rfIf.req0_ready;
      a1 = rfIf.req1_valid && rfIf.req1_ready;
      @(posedge Clk);
      #1;
      n++;
      if (a0) begin
        i0++;
        if (i0 < 3) begin
          rfIf.req0_addr = list0[i0]; rfIf.req0_data = 32'h0000_0100 + 32'(list0[i0]);
        end else rfIf.req0_valid = 1'b0;
      end
      if (a1) begin
        i1++;
        if (i1 < 3) begin
          rfIf.req1_addr = list1[i1]; rfIf.req1_data = 32'h0000_0200 + 32'(list1[i1]);
        end else rfIf.req1_valid = 1'b0;
      end
    end
    rfIf.req0_valid = 1'b0;
    rfIf.req1_valid = 1'b0;
    assertCount++;
    if (i0 != 3 || i1 != 3) begin
      failCount++; $display("[TB] FAIL contention_accept: got %0d/%0d accepted, required 3/3", i0, i1);
    end
    wait_drain();
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++; $display("[TB] FAIL contention_drain: got %0d pending, required 0", expQ.size());
    end
    assertCount++;
    if (writeCycles.size() != 6 || (writeCycles[writeCycles.size()-1] - writeCycles[0]) != 5) begin
      failCount++; $display("[TB] FAIL contention_gapless: got %0d writes, required 6 in 6 cycles",
                            writeCycles.size());
    end
  endtask

  task automatic test_single_write();
    $display("[TB] test_single_write");
    @(posedge Clk);
    #1;
    expQ.push_back('{addr: 5'd5, data: 32'hDEADBEEF, id: 1'b0});
    rfIf.req0_valid = 1'b1; rfIf.req0_addr = 5'd5; rfIf.req0_data = 32'hDEADBEEF;
    @(negedge Clk);
    assertCount++;
    if (rfIf.req0_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL single_ready: got %b, required 1", rfIf.req0_ready);
    end
    @(posedge Clk);
    #1 rfIf.req0_valid = 1'b0;
    @(negedge Clk);
    assertCount++;
    if (rfIf.RegWrite !== 1'b0 || rfIf.idle !== 1'b0) begin
      failCount++; $display("[TB] FAIL single_buffered: got RegWrite=%b idle=%b, required 0/0",
                            rfIf.RegWrite, rfIf.idle);
    end
    @(negedge Clk);
    assertCount++;
    if (rfIf.RegWrite !== 1'b1) begin
      failCount++; $display("[TB] FAIL single_latency: got RegWrite=%b, required 1", rfIf.RegWrite);
    end
    @(negedge Clk);
    assertCount++;
    if (rfIf.RegWrite !== 1'b0 || rfIf.idle !== 1'b1) begin
      failCount++; $display("[TB] FAIL single_after: got RegWrite=%b idle=%b, required 0/1",
                            rfIf.RegWrite, rfIf.idle);
    end
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++; $display("[TB] FAIL single_drain: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_zero_drop();
    $display("[TB] test_zero_drop");
    @(posedge Clk);
    #1;
    rfIf.req1_valid = 1'b1; rfIf.req1_addr = 5'd0; rfIf.req1_data = 32'h12345678;
    @(negedge Clk);
    assertCount++;
    if (rfIf.req1_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL zero_ready: got %b, required 1", rfIf.req1_ready);
    end
    @(posedge Clk);
    #1 rfIf.req1_valid = 1'b0;
    @(negedge Clk);
    assertCount++;
    if (rfIf.idle !== 1'b1) begin
      failCount++; $display("[TB] FAIL zero_not_buffered: got idle=%b, required 1", rfIf.idle);
    end
    repeat (3) @(negedge Clk);
    assertCount++;
    if (rfIf.RegWrite !== 1'b0) begin
      failCount++; $display("[TB] FAIL zero_no_write: got RegWrite=%b, required 0", rfIf.RegWrite);
    end
`ifdef REGFILE_ARB_STATS_EN
    assertCount++;
    if (zero_drop_count !== 16'd1) begin
      failCount++; $display("[TB] FAIL zero_drop_count: got %0d, required 1", zero_drop_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    writeCycles.delete();
    for (int k = 4; k < 8; k++) begin
      expQ.push_back('{addr: AWIDTH'(k), data: 32'h0000_0400 + 32'(k), id: 1'b1});
    end
    @(posedge Clk);
    #1;
    rfIf.req1_valid = 1'b1; rfIf.req1_addr = 5'd4; rfIf.req1_data = 32'h0000_0404;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      assertCount++;
      if (rfIf.req1_ready !== 1'b1) begin
        failCount++; $display("[TB] FAIL b2b_ready%0d: got %b, required 1", k, rfIf.req1_ready);
      end
      @(posedge Clk);
      #1;
      if (k < 3) begin
        rfIf.req1_addr = AWIDTH'(5 + k);
        rfIf.req1_data = 32'h0000_0405 + 32'(k);
      end else begin
        rfIf.req1_valid = 1'b0;
      end
    end
    wait_drain();
    assertCount++;
    if (writeCycles.size() != 4 || (writeCycles[writeCycles.size()-1] - writeCycles[0]) != 3) begin
      failCount++; $display("[TB] FAIL b2b_gapless: got %0d writes, required 4 in 4 cycles",
                            writeCycles.size());
    end
`ifdef REGFILE_ARB_STATS_EN
    assertCount++;
    if (grant_count0 !== 16'(grantsSeen0) || grant_count1 !== 16'(grantsSeen1)) begin
      failCount++; $display("[TB] FAIL grant_counts: got %0d/%0d, required %0d/%0d",
                            grant_count0, grant_count1, grantsSeen0, grantsSeen1);
    end
`endif
  endtask

  task automatic test_reset_midop();
    $display("[TB] test_reset_midop");
    @(posedge Clk);
    #1;
    rfIf.req0_valid = 1'b1; rfIf.req0_addr = 5'd20; rfIf.req0_data = 32'hBAD0_0020;
    rfIf.req1_valid = 1'b1; rfIf.req1_addr = 5'd21; rfIf.req1_data = 32'hBAD0_0021;
    @(negedge Clk);
    assertCount++;
    if (rfIf.req0_ready !== 1'b1 || rfIf.req1_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL midop_ready: got %b/%b, required 1/1",
                            rfIf.req0_ready, rfIf.req1_ready);
    end
    @(posedge Clk);
    #1;
    rfIf.req0_valid = 1'b0;
    rfIf.req1_valid = 1'b0;
    @(negedge Clk);
    assertCount++;
    if (rfIf.idle !== 1'b0 || rfIf.RegWrite !== 1'b0) begin
      failCount++; $display("[TB] FAIL midop_full: got idle=%b RegWrite=%b, required 0/0",
                            rfIf.idle, rfIf.RegWrite);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    assertCount++;
    if (rfIf.RegWrite !== 1'b0 || rfIf.idle !== 1'b1) begin
      failCount++; $display("[TB] FAIL midop_cleared: got RegWrite=%b idle=%b, required 0/1",
                            rfIf.RegWrite, rfIf.idle);
    end
    repeat (5) @(negedge Clk);
`ifdef REGFILE_ARB_STATS_EN
    assertCount++;
    if (grant_count0 !== 16'd0 || grant_count1 !== 16'd0 || zero_drop_count !== 16'd0) begin
      failCount++; $display("[TB] FAIL stats_reset: got %0d/%0d/%0d, required 0/0/0",
                            grant_count0, grant_count1, zero_drop_count);
    end
`endif
  endtask

  // Hard stop in case a scenario ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence; contention runs straight after reset so the
  // round-robin pointer starts at requester 0.
  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_zero_drop();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
